fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's fixed 128-bit FIFO.
- Adds generic width and depth, an occupancy count, configurable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a read-valid strobe.
- Sits between the stimulus/driver side and any consumer datapath.
- Keeps the i_/o_ port style so the existing driver and monitor clocking blocks extend without rework.

Parameters:
- DATA_W, 128, width of the write and read data words.
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- AF_THRESH, DEPTH-4, o_alm_full asserts when occupancy >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, o_alm_empty asserts when occupancy <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  sole clock; everything samples on the rising edge.
- rstn  input  1  synchronous, active-high reset. The port keeps the codebase name; reset is asserted when rstn=1.
- i_wren  input  1  write request.
- i_wrdata  input  DATA_W  write data.
- i_rden  input  1  read request.
- i_clr_err  input  1  clears o_ovf and o_udf.
- o_rddata  output  DATA_W  read data.
- o_rdvalid  output  1  o_rddata is valid this cycle.
- o_full  output  1  occupancy == DEPTH.
- o_empty  output  1  occupancy == 0.
- o_alm_full  output  1  occupancy >= AF_THRESH.
- o_alm_empty  output  1  occupancy <= AE_THRESH.
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_ovf  output  1  sticky: a write was attempted while full.
- o_udf  output  1  sticky: a read was attempted while empty.

Behaviour:
- Storage: register array of DEPTH x DATA_W.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy is held in a separate counter.
- Reset (rstn=1 at an edge):
  - pointers, count, o_rddata, o_rdvalid, o_full, o_ovf, o_udf and o_alm_full all go to 0.
  - o_empty=1; o_alm_empty=1.
  - Array contents are don't-care.
  - Reset mid-operation discards all stored data; no access is accepted in that cycle.
- Write acceptance: accepted iff i_wren && !o_full, using the registered flag from before the edge. The word is stored at wr_ptr and wr_ptr increments.
- Read acceptance: accepted iff i_rden && !o_empty, using the registered flag. rd_ptr increments.
- Simultaneous accepted read and write: count is unchanged. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- Count update:
  - count +1 on write-only, -1 on read-only.
  - o_full, o_empty, o_alm_full and o_alm_empty are registered and derived from the next count value, so they update on the same edge as o_count.
- Read latency (standard mode): 1 cycle.
  - On an accepted read at edge N, o_rddata takes mem[rd_ptr] and o_rdvalid=1 after edge N.
  - o_rdvalid=0 after any edge without an accepted read.
  - o_rddata holds its last value when not reading.
- Errors:
  - o_ovf is set on i_wren && o_full.
  - o_udf is set on i_rden && o_empty.
  - Both hold until i_clr_err=1 or reset.
  - If a set event and i_clr_err occur in the same cycle, set wins.
  - Rejected accesses never move pointers or change the count.
- Thresholds are checked at elaboration; an out-of-range value causes a $fatal.

Optional Feature:
Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - o_rddata = mem[rd_ptr] combinationally, showing the head word whenever !o_empty.
  - o_rdvalid = !o_empty.
  - An accepted i_rden pops the head, and the next word appears in the same cycle the pointer advances.
  - Zero-cycle read latency.
  - All flag, count and error behaviour is unchanged.
- Undefined: standard 1-cycle registered read as described under Behaviour.

Test Plan:
All scenarios use DATA_W=128, DEPTH=16, AF_THRESH=12, AE_THRESH=2.
1. Reset then idle -> o_empty=1, o_alm_empty=1, o_count=0, o_full=0, o_rdvalid=0, o_ovf=o_udf=0.
2. Write 0x1..0x10 on 16 back-to-back cycles -> o_alm_empty drops after the 3rd write; o_alm_full rises after the 12th; o_full=1 and o_count=16 after the 16th. Then read 16 words -> data 0x1..0x10 in order, each valid 1 cycle after its i_rden, with o_rdvalid high for 16 cycles.
3. When full, drive i_wren with 0xDEAD -> o_ovf=1, o_count stays 16, 0xDEAD is never read out. Pulse i_clr_err -> o_ovf=0.
4. When empty, drive i_rden -> o_udf=1, o_rdvalid=0, o_count stays 0.
5. At o_count=8, drive i_wren and i_rden together for 20 cycles -> o_count stays 8, data stays in order, and the pointers wrap past entry 15 without corruption.
6. With 5 words stored, assert rstn for 1 cycle -> o_count=0, o_empty=1. A following write of 0xA5 then read returns 0xA5. With FIFO_FWFT_EN, 0xA5 appears on o_rddata with o_rdvalid=1 one cycle after the write, before any i_rden.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle for fifo_sync_param. The i_/o_ names are as seen
// from the FIFO, so existing driver/monitor code keeps its signal names.
interface fifo_sync_param_if #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic              i_clr_err;
  logic [DATA_W-1:0] o_rddata;
  logic              o_rdvalid;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;
  logic [CW-1:0]     o_count;
  logic              o_ovf;
  logic              o_udf;

  // Driver / producer-consumer side
  modport master (
    output i_wren, i_wrdata, i_rden, i_clr_err,
    input  o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_ovf, o_udf
  );

  // FIFO side
  modport slave (
    input  i_wren, i_wrdata, i_rden, i_clr_err,
    output o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
           o_count, o_ovf, o_udf
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and a read-valid strobe.
// Optional macro FIFO_FWFT_EN: first-word-fall-through read port (head word
// shown combinationally while not empty). Undefined: 1-cycle registered read.
// rstn is a synchronous reset that is asserted HIGH (legacy port name).
module fifo_sync_param #(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  fifo_sync_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Elaboration-time parameter sanity
  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $fatal(1, "fifo_sync_param: DEPTH must be a power of two >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_sync_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_sync_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q, count_nxt;
  logic              full_q, empty_q, af_q, ae_q;
  logic              ovf_q, udf_q;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags; reset cycle accepts nothing
  assign wr_acc = bus.i_wren && !full_q  && !rstn;
  assign rd_acc = bus.i_rden && !empty_q && !rstn;

  // Next occupancy; simultaneous accepted read+write leaves it unchanged
  always_comb begin
    count_nxt = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  // Storage write; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.i_wrdata;
  end

  // Pointers, occupancy and flags derived from the next count
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= CW'(AF_THRESH));
      ae_q    <= (count_nxt <= CW'(AE_THRESH));
    end
  end

  // Sticky error flags; a new error in the clear cycle wins over the clear
  always_ff @(posedge clk) begin
    if (rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.i_wren && full_q)  ovf_q <= 1'b1;
      else if (bus.i_clr_err)    ovf_q <= 1'b0;
      if (bus.i_rden && empty_q) udf_q <= 1'b1;
      else if (bus.i_clr_err)    udf_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; popping advances rd_ptr and exposes the next one
  assign bus.o_rddata  = mem[rd_ptr];
  assign bus.o_rdvalid = !empty_q;
`else
  logic [DATA_W-1:0] rddata_q;
  logic              rdvalid_q;

  // Registered read: data lands one edge after an accepted read, then holds
  always_ff @(posedge clk) begin
    if (rstn) begin
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      rdvalid_q <= rd_acc;
      if (rd_acc) rddata_q <= mem[rd_ptr];
    end
  end

  assign bus.o_rddata  = rddata_q;
  assign bus.o_rdvalid = rdvalid_q;
`endif

  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_alm_full  = af_q;
  assign bus.o_alm_empty = ae_q;
  assign bus.o_count     = count_q;
  assign bus.o_ovf       = ovf_q;
  assign bus.o_udf       = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Table-driven bench for fifo_sync_param (DEPTH=16, AF=12, AE=2) with a data
// scoreboard: written words are queued on acceptance and popped on read-out.
module tb_fifo_sync_param;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int AE     = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic              rst, wren, rden, clr;
    logic [DATA_W-1:0] wd;
    int                cnt;
    logic              ovf, udf;
  } vec_t;

  vec_t              tbl[$];
  logic [DATA_W-1:0] sb[$];
  int                n_cmp = 0;
  int                n_err = 0;

  function automatic void add(logic rst, logic wren, logic rden, logic clr,
                              logic [DATA_W-1:0] wd, int cnt, logic ovf, logic udf);
    vec_t v;
    v.rst = rst; v.wren = wren; v.rden = rden; v.clr = clr;
    v.wd = wd; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int                prev_cnt;
    logic              wacc, racc;
    logic [DATA_W-1:0] exp_d;

    // 1: reset (with a write that must be ignored) then idle
    add(1, 1, 0, 0, 'h77, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    // 2: fill 0x1..0x10
    for (int i = 1; i <= 16; i++) add(0, 1, 0, 0, i, i, 0, 0);
    // 3: overflow, then write+read while full (write rejected), then clear
    add(0, 1, 0, 0, 'hDEAD, 16, 1, 0);
    add(0, 1, 1, 0, 'hBEEF, 15, 1, 0);
    add(0, 0, 0, 1, 0, 15, 0, 0);
    for (int i = 1; i <= 15; i++) add(0, 0, 1, 0, 0, 15 - i, 0, 0);
    // 4: underflow; write+read at empty (read rejected); set beats clear
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 'h33, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // 5: count 8, 20 cycles of simultaneous read/write (pointers wrap)
    for (int i = 1; i <= 8; i++)  add(0, 1, 0, 0, 'h100 + i, i, 0, 0);
    for (int i = 1; i <= 20; i++) add(0, 1, 1, 0, 'h200 + i, 8, 0, 0);
    for (int i = 1; i <= 3; i++)  add(0, 0, 1, 0, 0, 8 - i, 0, 0);
    // 6: reset with 5 stored, then write/read 0xA5
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 'hA5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    rstn = 1'b1;
    bus.i_wren = 1'b0; bus.i_rden = 1'b0; bus.i_clr_err = 1'b0; bus.i_wrdata = '0;
    prev_cnt = 0;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      rstn          = tbl[k].rst;
      bus.i_wren    = tbl[k].wren;
      bus.i_rden    = tbl[k].rden;
      bus.i_clr_err = tbl[k].clr;
      bus.i_wrdata  = tbl[k].wd;
      wacc = tbl[k].wren && prev_cnt != DEPTH && !tbl[k].rst;
      racc = tbl[k].rden && prev_cnt != 0     && !tbl[k].rst;
      if (tbl[k].rst) sb.delete();
      if (wacc) sb.push_back(tbl[k].wd);
`ifdef FIFO_FWFT_EN
      #1;
      chk($sformatf("v%0d rdvalid", k), bus.o_rdvalid, (prev_cnt != 0));
      if (prev_cnt != 0) chk($sformatf("v%0d head", k), bus.o_rddata, sb[0]);
      if (racc) void'(sb.pop_front());
`endif
      @(posedge clk);
      #1;
`ifndef FIFO_FWFT_EN
      chk($sformatf("v%0d rdvalid", k), bus.o_rdvalid, racc);
      if (racc) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL v%0d scoreboard: got read data %0h expected no data", k, bus.o_rddata);
        end else begin
          exp_d = sb.pop_front();
          chk($sformatf("v%0d rddata", k), bus.o_rddata, exp_d);
        end
      end
`endif
      chk($sformatf("v%0d count", k), bus.o_count, tbl[k].cnt);
      chk($sformatf("v%0d full", k), bus.o_full, (tbl[k].cnt == DEPTH));
      chk($sformatf("v%0d empty", k), bus.o_empty, (tbl[k].cnt == 0));
      chk($sformatf("v%0d alm_full", k), bus.o_alm_full, (tbl[k].cnt >= AF));
      chk($sformatf("v%0d alm_empty", k), bus.o_alm_empty, (tbl[k].cnt <= AE));
      chk($sformatf("v%0d ovf", k), bus.o_ovf, tbl[k].ovf);
      chk($sformatf("v%0d udf", k), bus.o_udf, tbl[k].udf);
      prev_cnt = tbl[k].cnt;
    end

    // Every accepted word must have been read out
    chk("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
